// File: rtl/l2_cache_ctrl.sv
// l2_cache_ctrl: blocking, line-granular controller for a set-associative L2
// array. Serves one read/write at a time. Misses pick a round-robin victim,
// write it back if it is dirty, fill from memory (reads only), update the array
// and then return a single-cycle response.
module l2_cache_ctrl #(
    parameter int unsigned  DATA_WIDTH  = 256,
    parameter int unsigned  ADDR_WIDTH  = 32,
    parameter int unsigned  INDEX_WIDTH = 9,
    parameter int unsigned  LINE_BITS   = 5,
    parameter int unsigned  ASSOC_BITS  = 2,
    localparam int unsigned WAYS        = 2 ** ASSOC_BITS,
    localparam int unsigned TAG_BITS    = ADDR_WIDTH - INDEX_WIDTH - LINE_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    // request side
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    // array port A
    output logic [ADDR_WIDTH-1:0] arr_addr,
    output logic [DATA_WIDTH-1:0] arr_data,
    output logic [WAYS-1:0]       arr_we,
    output logic [WAYS-1:0]       arr_dirty,
    output logic [WAYS-1:0]       arr_valid,
    output logic [WAYS-1:0]       arr_sel,
    output logic                  arr_lookup,
    input  logic [WAYS-1:0]       arr_hit,
    input  logic [WAYS-1:0]       arr_dirty_q,
    input  logic [TAG_BITS-1:0]   arr_tag_q,
    input  logic [DATA_WIDTH-1:0] arr_q,
    // memory side
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        COMPARE,
        WRITEBACK,
        FILL_REQ,
        FILL_WAIT,
        UPDATE,
        RESP
    } state_t;

    state_t                  state_q,  state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,   addr_d;    // line-aligned request address
    logic                    we_q,     we_d;
    logic [DATA_WIDTH-1:0]   wdata_q,  wdata_d;
    logic [DATA_WIDTH-1:0]   line_q,   line_d;    // hit data, victim line, then fill data
    logic [TAG_BITS-1:0]     vtag_q,   vtag_d;    // victim tag for the writeback address
    logic [ASSOC_BITS-1:0]   way_q,    way_d;     // way targeted by UPDATE
    logic                    miss_q,   miss_d;
    logic [ASSOC_BITS-1:0]   rr_ptr_q, rr_ptr_d;

    logic [INDEX_WIDTH-1:0]  req_index;
    logic [ASSOC_BITS-1:0]   hit_way;
    logic [WAYS-1:0]         hit_sel;
    logic [WAYS-1:0]         victim_sel;
    logic [WAYS-1:0]         target_sel;

    // Lowest set bit wins when the array reports more than one hitting way.
    function automatic logic [ASSOC_BITS-1:0] lowest_way(input logic [WAYS-1:0] hits);
        logic [ASSOC_BITS-1:0] w;
        w = '0;
        for (int unsigned i = WAYS; i > 0; i--) begin
            if (hits[ASSOC_BITS'(i - 1)]) begin
                w = ASSOC_BITS'(i - 1);
            end
        end
        return w;
    endfunction

    assign req_index  = addr_q[LINE_BITS +: INDEX_WIDTH];
    assign hit_way    = lowest_way(arr_hit);
    assign hit_sel    = WAYS'(1) << hit_way;
    assign victim_sel = WAYS'(1) << rr_ptr_q;
    assign target_sel = WAYS'(1) << way_q;

    // Next-state and output decode; all outputs are decoded from registered state
    // so memory request fields stay stable while the request is stalled.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        line_d        = line_q;
        vtag_d        = vtag_q;
        way_d         = way_q;
        miss_d        = miss_q;
        rr_ptr_d      = rr_ptr_q;

        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_data     = '0;
        arr_addr      = addr_q;
        arr_data      = '0;
        arr_we        = '0;
        arr_dirty     = '0;
        arr_valid     = '0;
        arr_sel       = '0;
        arr_lookup    = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = {req_addr[ADDR_WIDTH-1:LINE_BITS], {LINE_BITS{1'b0}}};
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    state_d = LOOKUP;
                end
            end

            LOOKUP: begin
                state_d = COMPARE;
            end

            COMPARE: begin
                arr_lookup = 1'b1;
                if (|arr_hit) begin
                    arr_sel = hit_sel;
                    way_d   = hit_way;
                    miss_d  = 1'b0;
                    if (we_q) begin
                        state_d = UPDATE;
                    end else begin
                        line_d  = arr_q;
                        state_d = RESP;
                    end
                end else begin
                    arr_sel = victim_sel;
                    way_d   = rr_ptr_q;
                    miss_d  = 1'b1;
                    line_d  = arr_q;
                    vtag_d  = arr_tag_q;
                    if (arr_dirty_q[rr_ptr_q]) begin
                        state_d = WRITEBACK;
                    end else if (!we_q) begin
                        state_d = FILL_REQ;
                    end else begin
                        state_d = UPDATE;
                    end
                end
            end

            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {vtag_q, req_index, {LINE_BITS{1'b0}}};
                mem_req_wdata = line_q;
                if (mem_req_ready) begin
                    state_d = we_q ? UPDATE : FILL_REQ;
                end
            end

            FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = addr_q;
                if (mem_req_ready) begin
                    state_d = FILL_WAIT;
                end
            end

            FILL_WAIT: begin
                if (mem_resp_valid) begin
                    line_d  = mem_resp_data;
                    state_d = UPDATE;
                end
            end

            UPDATE: begin
                arr_we    = target_sel;
                arr_valid = target_sel;
                arr_dirty = we_q ? target_sel : '0;
                arr_data  = we_q ? wdata_q : line_q;
                if (miss_q) begin
                    rr_ptr_d = rr_ptr_q + 1'b1;
                end
                state_d = RESP;
            end

            RESP: begin
                resp_valid = 1'b1;
                resp_data  = we_q ? '0 : line_q;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            line_q   <= '0;
            vtag_q   <= '0;
            way_q    <= '0;
            miss_q   <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            line_q   <= line_d;
            vtag_q   <= vtag_d;
            way_q    <= way_d;
            miss_q   <= miss_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
